// File: rtl/mem_write_checker.sv
// mem_write_checker: in-order hardware scoreboard on the processor data-memory store port.
// Latency: each store is judged on the edge that samples it; pass/fail/err_code/fail_* show one cycle later.
// Backpressure: exp_ready drops while the expected-write queue holds DEPTH entries; stores are never stalled.
//
// Ports:
//   clk, reset (async, active-low), clear (sync flush), start (IDLE->CHECK)
//   exp_valid/exp_ready/exp_adr/exp_data/exp_last : expected-write queue push side
//   MemWriteM/DataAdrM/WriteDataM                   : observed store stream from top
//   busy, pass, fail, err_code, match_count, fail_adr, fail_data : registered status
//   err_code: 00 none, 01 unexpected store, 10 address/data mismatch, 11 timeout
// Build option: define MWC_DATA_MASK_EN to add exp_mask, a per-entry data compare mask
//   (data bits with mask=0 are don't-care; the address is always compared in full).
module mem_write_checker #(
   parameter int DEPTH   = 8,     // expected-write queue entries, power of 2, >= 2
   parameter int TIMEOUT = 1024   // cycles in CHECK without a matching store before failing
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        start,
   input  logic        exp_valid,
   output logic        exp_ready,
   input  logic [31:0] exp_adr,
   input  logic [31:0] exp_data,
`ifdef MWC_DATA_MASK_EN
   input  logic [31:0] exp_mask,
`endif
   input  logic        exp_last,
   input  logic        MemWriteM,
   input  logic [31:0] DataAdrM,
   input  logic [31:0] WriteDataM,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic [1:0]  err_code,
   output logic [15:0] match_count,
   output logic [31:0] fail_adr,
   output logic [31:0] fail_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   // Timer value that, on one more idle cycle, completes TIMEOUT cycles in CHECK.
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   localparam logic [1:0] ERR_NONE       = 2'b00;
   localparam logic [1:0] ERR_UNEXPECTED = 2'b01;
   localparam logic [1:0] ERR_MISMATCH   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] data;
`ifdef MWC_DATA_MASK_EN
      logic [31:0] mask;
`endif
      logic        last;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      PASS  = 2'd2,
      FAIL  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Expected-write queue
   // ------------------------------------------------------------------
   entry_t          queueMem [DEPTH];
   logic [PW-1:0]   wrPtr;
   logic [PW-1:0]   rdPtr;
   logic [CW-1:0]   entryCount;
   entry_t          newEntry;
   entry_t          head;
   logic            queueEmpty;
   logic            pushEn;
   logic            popEn;

   // Readiness comes from the registered count only, so a pop in the same
   // cycle never lets a push into a full queue.
   assign exp_ready  = (entryCount != COUNT_FULL);
   assign queueEmpty = (entryCount == '0);

   // clear flushes the queue, so a push offered in the same cycle is dropped.
   assign pushEn = exp_valid && exp_ready && !clear;

   always_comb begin
      newEntry      = '0;
      newEntry.adr  = exp_adr;
      newEntry.data = exp_data;
`ifdef MWC_DATA_MASK_EN
      newEntry.mask = exp_mask;
`endif
      newEntry.last = exp_last;
   end

   assign head = queueMem[rdPtr];

   // Payload storage needs no reset: entries are only read when counted valid.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         queueMem[wrPtr] <= newEntry;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         entryCount <= '0;
      end else if (clear) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         entryCount <= '0;
      end else begin
         if (pushEn) begin
            wrPtr <= wrPtr + 1'b1;   // DEPTH is a power of 2, so this wraps naturally
         end
         if (popEn) begin
            rdPtr <= rdPtr + 1'b1;
         end
         entryCount <= entryCount + CW'(pushEn) - CW'(popEn);
      end
   end

   // ------------------------------------------------------------------
   // Store comparison against the queue head
   // ------------------------------------------------------------------
   state_t          state;
   logic [TW-1:0]   timer;
   logic            adrEq;
   logic            dataEq;
   logic            storeMatch;

   assign adrEq = (head.adr == DataAdrM);
`ifdef MWC_DATA_MASK_EN
   assign dataEq = (((head.data ^ WriteDataM) & head.mask) == 32'd0);
`else
   assign dataEq = (head.data == WriteDataM);
`endif

   // An empty queue never matches, even if a push lands on the same edge.
   assign storeMatch = (state == CHECK) && MemWriteM && !queueEmpty && adrEq && dataEq;
   assign popEn      = storeMatch && !clear;

   // ------------------------------------------------------------------
   // Checker FSM with registered status outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         timer       <= '0;
         busy        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         err_code    <= ERR_NONE;
         match_count <= 16'd0;
         fail_adr    <= 32'd0;
         fail_data   <= 32'd0;
      end else if (clear) begin
         state       <= IDLE;
         timer       <= '0;
         busy        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         err_code    <= ERR_NONE;
         match_count <= 16'd0;
         fail_adr    <= 32'd0;
         fail_data   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               // Stores seen while idle are ignored.
               if (start) begin
                  state       <= CHECK;
                  busy        <= 1'b1;
                  timer       <= '0;
                  match_count <= 16'd0;
               end
            end

            CHECK: begin
               if (MemWriteM) begin
                  if (queueEmpty) begin
                     state     <= FAIL;
                     busy      <= 1'b0;
                     fail      <= 1'b1;
                     err_code  <= ERR_UNEXPECTED;
                     fail_adr  <= DataAdrM;
                     fail_data <= WriteDataM;
                  end else if (!storeMatch) begin
                     // The offending head stays queued for post-mortem.
                     state     <= FAIL;
                     busy      <= 1'b0;
                     fail      <= 1'b1;
                     err_code  <= ERR_MISMATCH;
                     fail_adr  <= DataAdrM;
                     fail_data <= WriteDataM;
                  end else begin
                     timer <= '0;
                     if (match_count != 16'hFFFF) begin
                        match_count <= match_count + 16'd1;
                     end
                     if (head.last) begin
                        state <= PASS;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                     end
                  end
               end else if (timer == TIMER_LAST) begin
                  // A matching store on this same cycle would have won above.
                  state     <= FAIL;
                  busy      <= 1'b0;
                  fail      <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  fail_adr  <= 32'd0;
                  fail_data <= 32'd0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            PASS, FAIL: begin
               // Sticky verdict: only clear or reset leaves.
               state <= state;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed scenarios plus randomized store streams for mem_write_checker.
// Latency: expectations are compared 1 time unit after each rising clock edge.
// Backpressure: the reference model mirrors the DEPTH-entry expected-write queue limit.
module tb_mem_write_checker;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        start;
   logic        exp_valid;
   logic        exp_ready;
   logic [31:0] exp_adr;
   logic [31:0] exp_data;
   logic        exp_last;
   logic        MemWriteM;
   logic [31:0] DataAdrM;
   logic [31:0] WriteDataM;
   logic        busy;
   logic        pass;
   logic        fail;
   logic [1:0]  err_code;
   logic [15:0] match_count;
   logic [31:0] fail_adr;
   logic [31:0] fail_data;
`ifdef MWC_DATA_MASK_EN
   logic [31:0] exp_mask = 32'hFFFF_FFFF;
`endif

   int tests = 0;
   int fails = 0;

   mem_write_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .start       (start),
      .exp_valid   (exp_valid),
      .exp_ready   (exp_ready),
      .exp_adr     (exp_adr),
      .exp_data    (exp_data),
`ifdef MWC_DATA_MASK_EN
      .exp_mask    (exp_mask),
`endif
      .exp_last    (exp_last),
      .MemWriteM   (MemWriteM),
      .DataAdrM    (DataAdrM),
      .WriteDataM  (WriteDataM),
      .busy        (busy),
      .pass        (pass),
      .fail        (fail),
      .err_code    (err_code),
      .match_count (match_count),
      .fail_adr    (fail_adr),
      .fail_data   (fail_data)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] adr;
      logic [31:0] data;
      logic        last;
   } ent_t;

   ent_t        mQ[$];
   int          mPhase;   // 0 idle, 1 checking, 2 passed, 3 failed
   logic        mPass;
   logic        mFail;
   logic [1:0]  mErr;
   int          mCnt;
   logic [31:0] mFa;
   logic [31:0] mFd;
   int          mWait;

   task automatic mReset();
      mQ.delete();
      mPhase = 0; mPass = 0; mFail = 0; mErr = 2'd0;
      mCnt = 0; mFa = 0; mFd = 0; mWait = 0;
   endtask

   task automatic mFailWith(input logic [1:0] code, input logic [31:0] a, input logic [31:0] d);
      mPhase = 3; mFail = 1; mErr = code; mFa = a; mFd = d;
   endtask

   // One clock edge: capture the applied inputs, advance, then update the model.
   task automatic step();
      logic cClr, cSt, cV, cL, cMw;
      logic [31:0] cEa, cEd, cA, cD;
      bit pushOk;
      ent_t e;
      cClr = clear; cSt = start; cV = exp_valid; cL = exp_last; cMw = MemWriteM;
      cEa = exp_adr; cEd = exp_data; cA = DataAdrM; cD = WriteDataM;
      @(posedge clk);
      #1;
      if (cClr) begin
         mReset();
      end else begin
         pushOk = cV && (mQ.size() < DEPTH);
         if (mPhase == 0 && cSt) begin
            mPhase = 1; mCnt = 0; mWait = 0;
         end else if (mPhase == 1) begin
            if (cMw) begin
               if (mQ.size() == 0) mFailWith(2'd1, cA, cD);
               else if (mQ[0].adr != cA || mQ[0].data != cD) mFailWith(2'd2, cA, cD);
               else begin
                  if (mQ[0].last) begin mPhase = 2; mPass = 1; end
                  void'(mQ.pop_front());
                  if (mCnt < 65535) mCnt++;
                  mWait = 0;
               end
            end else begin
               mWait++;
               if (mWait == TIMEOUT) mFailWith(2'd3, 32'd0, 32'd0);
            end
         end
         if (pushOk) begin
            e.adr = cEa; e.data = cEd; e.last = cL;
            mQ.push_back(e);
         end
      end
   endtask

   task automatic idleInputs();
      clear = 0; start = 0; exp_valid = 0; exp_adr = 0; exp_data = 0; exp_last = 0;
      MemWriteM = 0; DataAdrM = 0; WriteDataM = 0;
   endtask

   task automatic pushOne(input logic [31:0] a, input logic [31:0] d, input logic l);
      exp_valid = 1; exp_adr = a; exp_data = d; exp_last = l;
      step();
      exp_valid = 0;
   endtask

   task automatic storeOne(input logic [31:0] a, input logic [31:0] d);
      MemWriteM = 1; DataAdrM = a; WriteDataM = d;
      step();
      MemWriteM = 0;
   endtask

   task automatic doClear();
      clear = 1; step(); clear = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idleInputs();
      reset = 0;
      mReset();
      #1;
      tests++; if (exp_ready !== 1'b1) begin fails++; $display("FAIL reset.exp_ready got=%0b want=1", exp_ready); end
      tests++; if ({busy, pass, fail, err_code} !== 5'b0) begin fails++; $display("FAIL reset.status got=%b want=00000", {busy, pass, fail, err_code}); end
      tests++; if ({match_count, fail_adr, fail_data} !== 80'd0) begin fails++; $display("FAIL reset.values got=%h want=0", {match_count, fail_adr, fail_data}); end
      @(posedge clk); #1;
      reset = 1;
      tests++; if (busy !== 1'b0 || exp_ready !== 1'b1) begin fails++; $display("FAIL reset.held busy=%0b ready=%0b want 0/1", busy, exp_ready); end
   endtask

   task automatic test_pass_dup();
      doClear();
      pushOne(32'h64, 32'h7, 1'b0);
      pushOne(32'h64, 32'h7, 1'b1);
      start = 1; step(); start = 0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pass_dup.busy got=%0b want=1", busy); end
      storeOne(32'h64, 32'h7);
      tests++; if (pass !== 1'b0 || match_count !== 16'd1) begin fails++; $display("FAIL pass_dup.mid pass=%0b cnt=%0d want 0/1", pass, match_count); end
      storeOne(32'h64, 32'h7);
      tests++; if (pass !== 1'b1 || fail !== 1'b0) begin fails++; $display("FAIL pass_dup.pass pass=%0b fail=%0b want 1/0", pass, fail); end
      tests++; if (match_count !== 16'd2 || err_code !== 2'b00) begin fails++; $display("FAIL pass_dup.cnt cnt=%0d err=%0d want 2/0", match_count, err_code); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pass_dup.busy_after got=%0b want=0", busy); end
   endtask

   task automatic test_mismatch();
      doClear();
      pushOne(32'h60, 32'h11, 1'b1);
      start = 1; step(); start = 0;
      storeOne(32'h60, 32'h12);
      tests++; if (fail !== 1'b1 || err_code !== 2'b10) begin fails++; $display("FAIL mismatch.err fail=%0b err=%0d want 1/2", fail, err_code); end
      tests++; if (fail_adr !== 32'h60 || fail_data !== 32'h12) begin fails++; $display("FAIL mismatch.capture adr=%h data=%h want 60/12", fail_adr, fail_data); end
      tests++; if (match_count !== 16'd0 || pass !== 1'b0) begin fails++; $display("FAIL mismatch.cnt cnt=%0d pass=%0b want 0/0", match_count, pass); end
      // Verdict is sticky: a later matching store and start change nothing.
      start = 1; storeOne(32'h60, 32'h11); start = 0;
      tests++; if (fail !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mismatch.sticky fail=%0b pass=%0b busy=%0b want 1/0/0", fail, pass, busy); end
   endtask

   task automatic test_unexpected();
      doClear();
      start = 1; step(); start = 0;
      storeOne(32'h5, 32'h0);
      tests++; if (fail !== 1'b1 || err_code !== 2'b01 || fail_adr !== 32'h5) begin fails++; $display("FAIL unexpected fail=%0b err=%0d adr=%h want 1/1/5", fail, err_code, fail_adr); end
      // Store with a same-cycle push into an empty queue is still unexpected.
      doClear();
      start = 1; step(); start = 0;
      exp_valid = 1; exp_adr = 32'h8; exp_data = 32'h9; exp_last = 1;
      storeOne(32'h8, 32'h9);
      exp_valid = 0;
      tests++; if (err_code !== 2'b01 || exp_ready !== 1'b1) begin fails++; $display("FAIL unexpected_push err=%0d ready=%0b want 1/1", err_code, exp_ready); end
   endtask

   task automatic test_timeout();
      int firstFail;
      firstFail = -1;
      doClear();
      pushOne(32'h40, 32'h1, 1'b1);
      start = 1; step(); start = 0;
      for (int n = 1; n <= 3 * TIMEOUT; n++) begin
         step();
         if (fail === 1'b1 && firstFail < 0) firstFail = n;
      end
      tests++; if (firstFail != TIMEOUT) begin fails++; $display("FAIL timeout.cycles got=%0d want=%0d", firstFail, TIMEOUT); end
      tests++; if (err_code !== 2'b11 || fail_adr !== 32'd0 || fail_data !== 32'd0) begin fails++; $display("FAIL timeout.err err=%0d adr=%h data=%h want 3/0/0", err_code, fail_adr, fail_data); end
      // Match on the last allowed cycle beats the timeout.
      doClear();
      pushOne(32'h44, 32'h2, 1'b1);
      start = 1; step(); start = 0;
      for (int n = 1; n < TIMEOUT; n++) step();
      storeOne(32'h44, 32'h2);
      tests++; if (pass !== 1'b1 || fail !== 1'b0) begin fails++; $display("FAIL timeout.edge_match pass=%0b fail=%0b want 1/0", pass, fail); end
   endtask

   task automatic test_full();
      doClear();
      for (int i = 0; i < DEPTH; i++) pushOne(32'(i * 4), 32'(i), 1'b0);
      tests++; if (exp_ready !== 1'b0) begin fails++; $display("FAIL full.ready got=%0b want=0", exp_ready); end
      exp_valid = 1; exp_adr = 32'h200; exp_data = 32'h99; exp_last = 1;
      step();
      tests++; if (exp_ready !== 1'b0) begin fails++; $display("FAIL full.held got=%0b want=0", exp_ready); end
      start = 1; step(); start = 0;
      storeOne(32'h0, 32'h0);
      tests++; if (exp_ready !== 1'b1 || match_count !== 16'd1) begin fails++; $display("FAIL full.after_pop ready=%0b cnt=%0d want 1/1", exp_ready, match_count); end
      step();   // the held 9th entry now enters
      exp_valid = 0;
      tests++; if (exp_ready !== 1'b0) begin fails++; $display("FAIL full.refill got=%0b want=0", exp_ready); end
      // Drain in order: entries 1..7 then the held 0x200 entry (last).
      for (int i = 1; i < DEPTH; i++) storeOne(32'(i * 4), 32'(i));
      storeOne(32'h200, 32'h99);
      tests++; if (pass !== 1'b1 || match_count !== 16'd9) begin fails++; $display("FAIL full.drain pass=%0b cnt=%0d want 1/9", pass, match_count); end
   endtask

   task automatic test_reset_mid_and_clear();
      doClear();
      for (int i = 0; i < 4; i++) pushOne(32'h300 + 32'(i * 4), 32'(i + 10), 1'b0);
      start = 1; step(); start = 0;
      storeOne(32'h300, 32'd10);
      tests++; if (busy !== 1'b1 || match_count !== 16'd1) begin fails++; $display("FAIL reset_mid.pre busy=%0b cnt=%0d want 1/1", busy, match_count); end
      #2 reset = 0;
      #1;
      tests++; if (busy !== 1'b0 || match_count !== 16'd0 || exp_ready !== 1'b1) begin fails++; $display("FAIL reset_mid.async busy=%0b cnt=%0d ready=%0b want 0/0/1", busy, match_count, exp_ready); end
      mReset();
      @(posedge clk); #1;
      reset = 1;
      start = 1; step(); start = 0;
      storeOne(32'h304, 32'd11);   // queue content was lost
      tests++; if (err_code !== 2'b01 || fail !== 1'b1) begin fails++; $display("FAIL reset_mid.lost err=%0d fail=%0b want 1/1", err_code, fail); end
      // clear during PASS returns to IDLE
      doClear();
      pushOne(32'h10, 32'hAA, 1'b1);
      start = 1; step(); start = 0;
      storeOne(32'h10, 32'hAA);
      tests++; if (pass !== 1'b1) begin fails++; $display("FAIL clear_pass.pre got=%0b want=1", pass); end
      doClear();
      tests++; if (pass !== 1'b0 || busy !== 1'b0 || match_count !== 16'd0) begin fails++; $display("FAIL clear_pass.idle pass=%0b busy=%0b cnt=%0d want 0/0/0", pass, busy, match_count); end
      storeOne(32'h77, 32'h77);    // ignored in IDLE
      tests++; if (fail !== 1'b0) begin fails++; $display("FAIL clear_pass.idle_store got=%0b want=0", fail); end
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 30; it++) begin
         idleInputs();
         doClear();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++)
            pushOne(32'h100 + 32'($urandom_range(0, 3) * 4), 32'($urandom_range(0, 3)), (i == n - 1));
         start = 1;
         for (int c = 0; c < 25; c++) begin
            exp_valid = ($urandom_range(0, 5) == 0);
            exp_adr   = 32'h100 + 32'($urandom_range(0, 3) * 4);
            exp_data  = 32'($urandom_range(0, 3));
            exp_last  = $urandom_range(0, 1);
            MemWriteM = ($urandom_range(0, 3) != 0);
            if (mQ.size() > 0 && $urandom_range(0, 7) != 0) begin
               DataAdrM = mQ[0].adr; WriteDataM = mQ[0].data;
            end else begin
               DataAdrM = 32'h100 + 32'($urandom_range(0, 3) * 4); WriteDataM = 32'($urandom_range(0, 3));
            end
            step();
            start = 0;
            tests++; if (busy !== (mPhase == 1)) begin fails++; $display("FAIL rand.busy it=%0d c=%0d got=%0b want=%0b", it, c, busy, (mPhase == 1)); end
            tests++; if (pass !== mPass || fail !== mFail) begin fails++; $display("FAIL rand.verdict it=%0d c=%0d got=%0b%0b want=%0b%0b", it, c, pass, fail, mPass, mFail); end
            tests++; if (err_code !== mErr) begin fails++; $display("FAIL rand.err it=%0d c=%0d got=%0d want=%0d", it, c, err_code, mErr); end
            tests++; if (match_count !== 16'(mCnt)) begin fails++; $display("FAIL rand.count it=%0d c=%0d got=%0d want=%0d", it, c, match_count, mCnt); end
            tests++; if (fail_adr !== mFa || fail_data !== mFd) begin fails++; $display("FAIL rand.capture it=%0d c=%0d got=%h/%h want=%h/%h", it, c, fail_adr, fail_data, mFa, mFd); end
            tests++; if (exp_ready !== (mQ.size() < DEPTH)) begin fails++; $display("FAIL rand.ready it=%0d c=%0d got=%0b want=%0b", it, c, exp_ready, (mQ.size() < DEPTH)); end
         end
      end
      idleInputs();
   endtask

   initial begin
      test_reset();
      test_pass_dup();
      test_mismatch();
      test_unexpected();
      test_timeout();
      test_full();
      test_reset_mid_and_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
